// File: rtl/cop_perf_counters.sv
// Coprocessor performance-monitor: NUM_CNT event counters with overflow IRQ and CRD/CWR register access.
// Optional shadow snapshot registers at GEN 16+i are built when COP_PERF_SNAPSHOT_EN is defined.
module cop_perf_counters #(
   parameter int NUM_CNT = 4,
   parameter int CNT_W   = 32
) (
   input  logic        SYSCLK,
   input  logic        RESET,
   input  logic        CNTINST,
   input  logic        CNTIMISS,
   input  logic        CNTISTALL,
   input  logic        CNTDMISS,
   input  logic        CNTDSTALL,
   input  logic        CNTDLOAD,
   input  logic        CNTDSTORE,
   input  logic [4:0]  CRDADDR,
   input  logic        CRDGEN,
   input  logic        CRDCON,
   output logic [31:0] CRDDATA,
   input  logic [4:0]  CWRADDR,
   input  logic        CWRGEN,
   input  logic        CWRCON,
   input  logic [31:0] CWRDATA,
   output logic        CPINT
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 gen_q, gen_d;
   logic                 sat_q, sat_d;
   logic [NUM_CNT-1:0]   irqen_q, irqen_d;
   logic [NUM_CNT-1:0]   ovf_q, ovf_d;
   logic [4*NUM_CNT-1:0] sel_q, sel_d;
   logic [CNT_W-1:0]     cnt_q [NUM_CNT];
   logic [CNT_W-1:0]     cnt_d [NUM_CNT];
   logic                 cpint_q, cpint_d;

   logic [15:0]          ev;
   logic [NUM_CNT-1:0]   inc;
   logic [NUM_CNT-1:0]   gen_hit;
   logic [NUM_CNT-1:0]   gen_blk;
   logic                 wr_ctrl, wr_stat, wr_sel;
   logic [31:0]          rd_data;

   // Event code table: 0 off, 1..7 strobes, 8 every cycle, 9..15 off.
   assign ev = {7'b0, 1'b1, CNTDSTORE, CNTDLOAD, CNTDSTALL, CNTDMISS,
                CNTISTALL, CNTIMISS, CNTINST, 1'b0};

   assign wr_ctrl = CWRCON && (CWRADDR == 5'd0);
   assign wr_stat = CWRCON && (CWRADDR == 5'd1);
   assign wr_sel  = CWRCON && (CWRADDR == 5'd2);

   always_comb begin
      inc     = '0;
      gen_hit = '0;
      gen_blk = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         inc[i]     = gen_q && ev[sel_q[4*i +: 4]];
         // Any GEN write aimed at a counter drops its increment, even when CON wins the write.
         gen_blk[i] = CWRGEN && (CWRADDR == 5'(i));
         gen_hit[i] = gen_blk[i] && !CWRCON;
      end
   end

   always_comb begin
      gen_d   = gen_q;
      sat_d   = sat_q;
      irqen_d = irqen_q;
      sel_d   = sel_q;
      ovf_d   = ovf_q;
      cpint_d = |(ovf_q & irqen_q);
      if (wr_ctrl) begin
         gen_d   = CWRDATA[0];
         sat_d   = CWRDATA[1];
         irqen_d = CWRDATA[8 +: NUM_CNT];
      end
      if (wr_sel) begin
         sel_d = CWRDATA[4*NUM_CNT-1:0];
      end
      if (wr_stat) begin
         ovf_d = ovf_q & ~CWRDATA[NUM_CNT-1:0];
      end
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (gen_hit[i]) begin
            cnt_d[i] = CWRDATA[CNT_W-1:0];
         end else if (inc[i] && !gen_blk[i]) begin
            // Overflow sets after the W1C clear so a same-cycle set wins.
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = sat_q ? CNT_MAX : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         gen_q   <= 1'b0;
         sat_q   <= 1'b0;
         irqen_q <= '0;
         sel_q   <= '0;
         ovf_q   <= '0;
         cpint_q <= 1'b0;
         for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      end else begin
         gen_q   <= gen_d;
         sat_q   <= sat_d;
         irqen_q <= irqen_d;
         sel_q   <= sel_d;
         ovf_q   <= ovf_d;
         cpint_q <= cpint_d;
         for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef COP_PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] snap_q [NUM_CNT];

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
      end else if (wr_ctrl && CWRDATA[2]) begin
         for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= cnt_q[i];
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      if (CRDCON) begin
         case (CRDADDR)
            5'd0: begin
               rd_data[0]           = gen_q;
               rd_data[1]           = sat_q;
               rd_data[8 +: NUM_CNT] = irqen_q;
            end
            5'd1:    rd_data[NUM_CNT-1:0]   = ovf_q;
            5'd2:    rd_data[4*NUM_CNT-1:0] = sel_q;
            default: rd_data = '0;
         endcase
      end else if (CRDGEN) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (CRDADDR == 5'(i)) rd_data[CNT_W-1:0] = cnt_q[i];
`ifdef COP_PERF_SNAPSHOT_EN
            if (CRDADDR == 5'(16 + i)) rd_data[CNT_W-1:0] = snap_q[i];
`endif
         end
      end
   end

   assign CRDDATA = rd_data;
   assign CPINT   = cpint_q;

endmodule

// File: tb/tb_cop_perf_counters.sv
// Directed bench for cop_perf_counters: counting, wrap/saturate, IRQ, write priority, read path, reset.
module tb_cop_perf_counters;

   logic        clk;
   logic        rst;
   logic        ev_inst, ev_imiss, ev_istall, ev_dmiss, ev_dstall, ev_dload, ev_dstore;
   logic [4:0]  rd_addr;
   logic        rd_gen, rd_con;
   logic [31:0] rd_data;
   logic [4:0]  wr_addr;
   logic        wr_gen, wr_con;
   logic [31:0] wr_data;
   logic        cpint;

   int checks = 0;
   int errors = 0;

   cop_perf_counters #(.NUM_CNT(4), .CNT_W(32)) dut (
      .SYSCLK   (clk),
      .RESET    (rst),
      .CNTINST  (ev_inst),
      .CNTIMISS (ev_imiss),
      .CNTISTALL(ev_istall),
      .CNTDMISS (ev_dmiss),
      .CNTDSTALL(ev_dstall),
      .CNTDLOAD (ev_dload),
      .CNTDSTORE(ev_dstore),
      .CRDADDR  (rd_addr),
      .CRDGEN   (rd_gen),
      .CRDCON   (rd_con),
      .CRDDATA  (rd_data),
      .CWRADDR  (wr_addr),
      .CWRGEN   (wr_gen),
      .CWRCON   (wr_con),
      .CWRDATA  (wr_data),
      .CPINT    (cpint)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic con, input logic [4:0] a,
                         input logic [31:0] exp);
      rd_con  = con;
      rd_gen  = !con;
      rd_addr = a;
      #1;
      chk(tag, rd_data, exp);
      rd_con  = 1'b0;
      rd_gen  = 1'b0;
   endtask

   task automatic wr(input logic con, input logic [4:0] a, input logic [31:0] d);
      wr_con  = con;
      wr_gen  = !con;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_con  = 1'b0;
      wr_gen  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {ev_inst, ev_imiss, ev_istall, ev_dmiss, ev_dstall, ev_dload, ev_dstore} = '0;
      rd_addr = '0; rd_gen = 1'b0; rd_con = 1'b0;
      wr_addr = '0; wr_gen = 1'b0; wr_con = 1'b0; wr_data = '0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      chk_rd("rst_ctrl", 1'b1, 5'd0, 32'h0);
      chk_rd("rst_stat", 1'b1, 5'd1, 32'h0);
      chk_rd("rst_sel",  1'b1, 5'd2, 32'h0);
      chk_rd("rst_cnt0", 1'b0, 5'd0, 32'h0);
      chk_rd("rst_cnt1", 1'b0, 5'd1, 32'h0);
      chk_rd("rst_cnt2", 1'b0, 5'd2, 32'h0);
      chk_rd("rst_cnt3", 1'b0, 5'd3, 32'h0);
      chk("rst_cpint", {31'b0, cpint}, 32'h0);

      // Basic counting over 10 enabled cycles
      wr(1'b1, 5'd2, 32'h0000_8421);
      wr(1'b1, 5'd0, 32'h0000_0001);
      for (int c = 0; c < 10; c++) begin
         ev_inst  = (c < 5);
         ev_imiss = (c < 3);
         ev_dmiss = (c < 2);
         tick();
      end
      ev_inst = 1'b0; ev_imiss = 1'b0; ev_dmiss = 1'b0;
      chk_rd("cnt0_inst",  1'b0, 5'd0, 32'd5);
      chk_rd("cnt1_imiss", 1'b0, 5'd1, 32'd3);
      chk_rd("cnt2_dmiss", 1'b0, 5'd2, 32'd2);
      chk_rd("cnt3_every", 1'b0, 5'd3, 32'd10);
      chk_rd("stat_none",  1'b1, 5'd1, 32'h0);

      // Wrap with IRQ enabled
      wr(1'b0, 5'd0, 32'hFFFF_FFFE);
      wr(1'b1, 5'd0, 32'h0000_0101);
      ev_inst = 1'b1;
      tick();
      chk_rd("wrap_max", 1'b0, 5'd0, 32'hFFFF_FFFF);
      tick();
      chk_rd("wrap_zero", 1'b0, 5'd0, 32'h0);
      chk_rd("wrap_stat", 1'b1, 5'd1, 32'h1);
      chk("wrap_cpint_lat", {31'b0, cpint}, 32'h0);
      tick();
      ev_inst = 1'b0;
      chk_rd("wrap_one", 1'b0, 5'd0, 32'h1);
      chk("wrap_cpint_hi", {31'b0, cpint}, 32'h1);
      wr(1'b1, 5'd1, 32'h1);
      chk_rd("w1c_stat", 1'b1, 5'd1, 32'h0);
      chk("w1c_cpint_lat", {31'b0, cpint}, 32'h1);
      tick();
      chk("w1c_cpint_lo", {31'b0, cpint}, 32'h0);

      // Saturating overflow, then W1C racing a new overflow
      wr(1'b0, 5'd0, 32'hFFFF_FFFE);
      wr(1'b1, 5'd0, 32'h0000_0103);
      ev_inst = 1'b1;
      tick();
      chk_rd("sat_max", 1'b0, 5'd0, 32'hFFFF_FFFF);
      chk_rd("sat_stat0", 1'b1, 5'd1, 32'h0);
      tick();
      chk_rd("sat_hold1", 1'b0, 5'd0, 32'hFFFF_FFFF);
      chk_rd("sat_stat1", 1'b1, 5'd1, 32'h1);
      tick();
      chk_rd("sat_hold2", 1'b0, 5'd0, 32'hFFFF_FFFF);
      wr(1'b1, 5'd1, 32'h1);
      chk_rd("set_beats_clr", 1'b1, 5'd1, 32'h1);
      ev_inst = 1'b0;
      wr(1'b1, 5'd1, 32'h1);
      chk_rd("sat_clr", 1'b1, 5'd1, 32'h0);
      tick();
      chk("sat_cpint_lo", {31'b0, cpint}, 32'h0);

      // CON and GEN write together: CON wins, counter unchanged despite an event
      ev_inst = 1'b1;
      wr_con = 1'b1; wr_gen = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_0201;
      tick();
      wr_con = 1'b0; wr_gen = 1'b0;
      ev_inst = 1'b0;
      chk_rd("dual_ctrl", 1'b1, 5'd0, 32'h0000_0201);
      chk_rd("dual_cnt0", 1'b0, 5'd0, 32'hFFFF_FFFF);
      ev_imiss = 1'b1;
      wr(1'b0, 5'd1, 32'h0000_0100);
      chk_rd("wr_beats_inc", 1'b0, 5'd1, 32'h0000_0100);
      ev_imiss = 1'b0;

      // Read-during-write returns old value; read priority and unmapped space
      wr_con = 1'b1; wr_addr = 5'd2; wr_data = 32'h0000_1234;
      chk_rd("rdw_old", 1'b1, 5'd2, 32'h0000_8421);
      tick();
      wr_con = 1'b0;
      chk_rd("rdw_new", 1'b1, 5'd2, 32'h0000_1234);
      rd_con = 1'b1; rd_gen = 1'b1; rd_addr = 5'd0;
      #1;
      chk("rd_con_prio", rd_data, 32'h0000_0201);
      rd_con = 1'b0; rd_gen = 1'b0;
      #1;
      chk("rd_idle", rd_data, 32'h0);
      chk_rd("unmap_con3", 1'b1, 5'd3, 32'h0);
      chk_rd("unmap_gen4", 1'b0, 5'd4, 32'h0);

      // Snapshot request in CTRL bit2
      wr(1'b1, 5'd0, 32'h0);
      wr(1'b0, 5'd0, 32'd7);
      wr(1'b0, 5'd1, 32'd3);
      wr(1'b0, 5'd2, 32'd0);
      wr(1'b0, 5'd3, 32'd20);
      wr(1'b1, 5'd2, 32'h0000_8421);
      wr(1'b1, 5'd0, 32'h0000_0005);
      tick();
      chk_rd("snap_ctrl", 1'b1, 5'd0, 32'h1);
      chk_rd("snap_live3", 1'b0, 5'd3, 32'd21);
`ifdef COP_PERF_SNAPSHOT_EN
      chk_rd("snap16", 1'b0, 5'd16, 32'd7);
      chk_rd("snap17", 1'b0, 5'd17, 32'd3);
      chk_rd("snap18", 1'b0, 5'd18, 32'd0);
      chk_rd("snap19", 1'b0, 5'd19, 32'd20);
`else
      chk_rd("nosnap16", 1'b0, 5'd16, 32'h0);
      chk_rd("nosnap19", 1'b0, 5'd19, 32'h0);
`endif

      // Reset during active counting
      ev_inst = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_rd("mid_rst_ctrl", 1'b1, 5'd0, 32'h0);
      chk_rd("mid_rst_sel",  1'b1, 5'd2, 32'h0);
      chk_rd("mid_rst_cnt0", 1'b0, 5'd0, 32'h0);
      chk_rd("mid_rst_cnt3", 1'b0, 5'd3, 32'h0);
      chk("mid_rst_cpint", {31'b0, cpint}, 32'h0);
      tick();
      chk_rd("post_rst_cnt0", 1'b0, 5'd0, 32'h0);
      ev_inst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
